// File: rtl/gray_ptr_fifo_if.sv
// Producer/consumer handshake bundle for gray_ptr_fifo.
// master = the user side, slave = the FIFO.
interface gray_ptr_fifo_if #(
    parameter int DATA_W = 8
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              empty;

    modport master (output wr_en, wr_data, rd_en, input full, rd_data, empty);
    modport slave  (input wr_en, wr_data, rd_en, output full, rd_data, empty);
endinterface

// File: rtl/gray_ptr_fifo.sv
// Single-clock FIFO built with the dual-clock pointer-crossing structure:
// Gray pointers pass through 2-flop synchronisers, so the flags are conservative.
module gray_ptr_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    gray_ptr_fifo_if.slave bus
);
    localparam int PTR_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_bin, wr_ptr_gray, wr_ptr_gray_sync1, wr_ptr_gray_sync2;
    logic [PTR_W-1:0]  rd_ptr_bin, rd_ptr_gray, rd_ptr_gray_sync1, rd_ptr_gray_sync2;
    logic [PTR_W-1:0]  wr_ptr_bin_d, wr_ptr_gray_d, rd_ptr_bin_d, rd_ptr_gray_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              full, empty, wr_fire, rd_fire;

    // Flags compare a local pointer against the synchronised (lagging) remote one.
    assign empty   = (rd_ptr_gray == wr_ptr_gray_sync2);
    assign full    = (wr_ptr_gray == {~rd_ptr_gray_sync2[PTR_W-1:PTR_W-2],
                                       rd_ptr_gray_sync2[PTR_W-3:0]});
    assign wr_fire = bus.wr_en && !full;
    assign rd_fire = bus.rd_en && !empty;

    always_comb begin
        wr_ptr_bin_d = wr_ptr_bin;
        rd_ptr_bin_d = rd_ptr_bin;
        rd_data_d    = rd_data_q;
        if (wr_fire) wr_ptr_bin_d = wr_ptr_bin + PTR_ONE;
        if (rd_fire) begin
            rd_ptr_bin_d = rd_ptr_bin + PTR_ONE;
            rd_data_d    = mem[rd_ptr_bin[ADDR_W-1:0]];
        end
        wr_ptr_gray_d = wr_ptr_bin_d ^ (wr_ptr_bin_d >> 1);
        rd_ptr_gray_d = rd_ptr_bin_d ^ (rd_ptr_bin_d >> 1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_bin        <= '0;
            wr_ptr_gray       <= '0;
            rd_ptr_bin        <= '0;
            rd_ptr_gray       <= '0;
            wr_ptr_gray_sync1 <= '0;
            wr_ptr_gray_sync2 <= '0;
            rd_ptr_gray_sync1 <= '0;
            rd_ptr_gray_sync2 <= '0;
            rd_data_q         <= '0;
        end else begin
            wr_ptr_bin        <= wr_ptr_bin_d;
            wr_ptr_gray       <= wr_ptr_gray_d;
            rd_ptr_bin        <= rd_ptr_bin_d;
            rd_ptr_gray       <= rd_ptr_gray_d;
            wr_ptr_gray_sync1 <= wr_ptr_gray;
            wr_ptr_gray_sync2 <= wr_ptr_gray_sync1;
            rd_ptr_gray_sync1 <= rd_ptr_gray;
            rd_ptr_gray_sync2 <= rd_ptr_gray_sync1;
            rd_data_q         <= rd_data_d;
        end
    end

    // Storage is never cleared; reset only discards it by zeroing the pointers.
    always_ff @(posedge clk) begin
        if (rst_n && wr_fire) mem[wr_ptr_bin[ADDR_W-1:0]] <= bus.wr_data;
    end

    assign bus.full    = full;
    assign bus.empty   = empty;
    assign bus.rd_data = rd_data_q;
endmodule

// File: tb/tb_gray_ptr_fifo.sv
// Directed bench for gray_ptr_fifo: reset, ordering, flag latency, full, wrap, concurrent ops.
module tb_gray_ptr_fifo;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    logic wrap_seen = 1'b0;
    logic [4:0] wr_prev = '0;
    logic [7:0] q[$];

    gray_ptr_fifo_if #(.DATA_W(8)) bus ();

    gray_ptr_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (wr_prev == 5'd31 && dut.wr_ptr_bin == 5'd0) wrap_seen = 1'b1;
        wr_prev = dut.wr_ptr_bin;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns 2 time units after the edge so sampling stays clear of it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic write1(input logic [7:0] d);
        bus.wr_en = 1'b1; bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    initial begin
        int nw, nr, iter;
        logic [7:0] exp_d;
        logic do_wr, do_rd;
        rst_n = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wr_data = '0;

        // 1: reset
        tick(); tick();
        rst_n = 1'b1;
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_rd_data", bus.rd_data, 8'h00);
        check("rst_ptrs", {dut.wr_ptr_bin, dut.rd_ptr_bin, dut.wr_ptr_gray, dut.rd_ptr_gray,
                           dut.wr_ptr_gray_sync1, dut.wr_ptr_gray_sync2,
                           dut.rd_ptr_gray_sync1, dut.rd_ptr_gray_sync2}, 0);

        // 2: write 0x11..0x88, idle, read back in order
        for (int i = 1; i <= 8; i++) write1(8'(i * 8'h11));
        repeat (5) tick();
        check("t2_not_empty", bus.empty, 0);
        bus.rd_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("t2_rd%0d", i), bus.rd_data, 8'(i * 8'h11));
        end
        bus.rd_en = 1'b0;
        check("t2_empty", bus.empty, 1);
        check("t2_rd_ptr", dut.rd_ptr_bin, 5'd8);

        // 3: empty deassert latency; read while empty must be ignored
        bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0;
        check("t3_rd_when_empty_ptr", dut.rd_ptr_bin, 5'd8);
        check("t3_rd_when_empty_data", bus.rd_data, 8'h88);
        write1(8'hA5);
        check("t3_empty_N", bus.empty, 1);
        tick();
        check("t3_empty_N1", bus.empty, 1);
        tick();
        check("t3_empty_N2", bus.empty, 0);
        bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0;
        check("t3_rd", bus.rd_data, 8'hA5);
        check("t3_empty_after", bus.empty, 1);
        repeat (3) tick();

        // mid-operation reset, then 4: fill to full
        write1(8'h77);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("rst2_empty", bus.empty, 1);
        check("rst2_ptr", {dut.wr_ptr_bin, dut.rd_ptr_bin}, 0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t4_not_full%0d", i), bus.full, 0);
            write1(8'(8'h20 + i));
        end
        check("t4_full", bus.full, 1);
        check("t4_wr_gray", dut.wr_ptr_gray, 5'b11000);
        write1(8'hFF);
        check("t4_ovf_ptr", dut.wr_ptr_bin, 5'd16);
        bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0;
        check("t4_rd0", bus.rd_data, 8'h20);
        check("t4_full_N", bus.full, 1);
        tick();
        check("t4_full_N1", bus.full, 1);
        tick();
        check("t4_full_N2", bus.full, 0);
        bus.rd_en = 1'b1;
        for (int i = 1; i < 16; i++) begin
            tick();
            check($sformatf("t4_drain%0d", i), bus.rd_data, 8'(8'h20 + i));
        end
        bus.rd_en = 1'b0;
        check("t4_empty", bus.empty, 1);
        repeat (3) tick();

        // 5: random interleave of 40 writes and 40 reads across the pointer wrap
        nw = 0; nr = 0; iter = 0;
        while ((nw < 40 || nr < 40) && iter < 2000) begin
            iter++;
            do_wr = (nw < 40) && !bus.full;
            do_rd = (nr < 40) && !bus.empty;
            if (do_wr && do_rd) begin
                if ($urandom_range(0, 1) == 0) do_rd = 1'b0;
                else do_wr = 1'b0;
            end
            if (do_wr) begin
                bus.wr_en = 1'b1; bus.wr_data = 8'($urandom);
                q.push_back(bus.wr_data);
                nw++;
            end
            if (do_rd) begin
                bus.rd_en = 1'b1;
                nr++;
            end
            tick();
            bus.wr_en = 1'b0; bus.rd_en = 1'b0;
            if (do_rd) begin
                exp_d = q.pop_front();
                check($sformatf("t5_rd%0d", nr), bus.rd_data, exp_d);
            end
            repeat ($urandom_range(0, 4)) tick();
        end
        check("t5_writes", nw, 40);
        check("t5_reads", nr, 40);
        check("t5_wr_ptr", dut.wr_ptr_bin, 5'd24);
        check("t5_rd_ptr", dut.rd_ptr_bin, 5'd24);
        check("t5_wrap", wrap_seen, 1);

        // 6: 4 entries, then 10 cycles of simultaneous read+write
        q.delete();
        for (int i = 0; i < 4; i++) begin
            q.push_back(8'(8'h50 + i));
            write1(8'(8'h50 + i));
        end
        repeat (3) tick();
        bus.rd_en = 1'b1; bus.wr_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.wr_data = 8'(8'h60 + i);
            q.push_back(bus.wr_data);
            tick();
            exp_d = q.pop_front();
            check($sformatf("t6_rd%0d", i), bus.rd_data, exp_d);
            check($sformatf("t6_occ%0d", i), 5'(dut.wr_ptr_bin - dut.rd_ptr_bin), 5'd4);
        end
        bus.wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_d = q.pop_front();
            check($sformatf("t6_drain%0d", i), bus.rd_data, exp_d);
        end
        bus.rd_en = 1'b0;
        check("t6_empty", bus.empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
